// File: rtl/multi_channel_normal_queue_pkg.sv
// Shared helpers for the multi-channel normal queue.
// Width derivations and the default pointer type.
package normal_queue_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int DEF_DEPTH = 2;
  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

  // Pointer with wrap bit for the default depth
  typedef logic [DEF_PTR_W:0] ptr_t;

endpackage

// File: rtl/multi_channel_normal_queue_if.sv
// Enqueue/dequeue bundle of the multi-channel queue.
// master drives producers/consumer side, slave is the queue.
interface multi_channel_normal_queue_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int NUM_CH = 4
);
  import normal_queue_pkg::*;

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CH_W  = ch_w(NUM_CH);

  logic [NUM_CH-1:0]           w_val;
  logic [NUM_CH-1:0]           w_rdy;
  logic [NUM_CH*WIDTH-1:0]     w_msg;
  logic                        r_val;
  logic                        r_rdy;
  logic [WIDTH-1:0]            r_msg;
  logic [CH_W-1:0]             r_ch;
  logic [NUM_CH*(PTR_W+1)-1:0] count;

  modport master (
    output w_val, w_msg, r_rdy,
    input  w_rdy, r_val, r_msg, r_ch, count
  );

  modport slave (
    input  w_val, w_msg, r_rdy,
    output w_rdy, r_val, r_msg, r_ch, count
  );

endinterface

// File: rtl/multi_channel_normal_queue_rr_arbiter.sv
// Round-robin arbiter with grant lock for the queue output.
// Owns the priority pointer and the held grant.
module rr_arbiter
  import normal_queue_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              lock,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [CH_W-1:0]   gnt_bin
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] ONE  = CH_W'(1);

  logic [CH_W-1:0] prio_q;
  logic [CH_W-1:0] held_q;
  logic            locked_q;
  logic [CH_W-1:0] pick;
  logic            found;
  logic [CH_W-1:0] nxt;
  int              idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(prio_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_bin = locked_q ? held_q : pick;
    gnt_oh  = '0;
    if (locked_q || found) gnt_oh[gnt_bin] = 1'b1;
  end

  assign nxt = (gnt_bin == LAST) ? '0 : gnt_bin + ONE;

  // A stalled grant is frozen until it is consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q   <= '0;
      held_q   <= '0;
      locked_q <= 1'b0;
    end else if (en) begin
      prio_q   <= nxt;
      locked_q <= 1'b0;
    end else if (lock && !locked_q) begin
      held_q   <= gnt_bin;
      locked_q <= 1'b1;
    end
  end

endmodule

// File: rtl/multi_channel_normal_queue.sv
// NUM_CH val/rdy FIFOs merged onto one tagged dequeue port.
// Optional same-cycle pass-through: QUEUE_BYPASS_EN.
module multi_channel_normal_queue
  import normal_queue_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int NUM_CH = 4
) (
  input  logic clk,
  input  logic reset_n,
  multi_channel_normal_queue_if.slave q
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CH_W  = ch_w(NUM_CH);

  typedef logic [PTR_W:0] ch_ptr_t;

  localparam ch_ptr_t PTR_ONE = ch_ptr_t'(1);

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] byp;
  logic [NUM_CH-1:0] w_fire;
  logic [NUM_CH-1:0] r_fire;
  logic [NUM_CH-1:0] gnt_oh;
  logic [CH_W-1:0]   gnt_bin;
  logic              deq;
  logic              stall;
  logic [WIDTH-1:0]  head [NUM_CH];

  assign q.w_rdy = {NUM_CH{reset_n}} & ~full;
  assign q.r_val = |req;
  assign q.r_ch  = gnt_bin;
  assign deq     = q.r_val & q.r_rdy;
  assign stall   = q.r_val & ~q.r_rdy;

`ifdef QUEUE_BYPASS_EN
  // An empty channel offering data competes this cycle
  assign req = ~empty | (q.w_val & q.w_rdy);
  assign byp = empty & gnt_oh & {NUM_CH{deq}};
`else
  assign req = ~empty;
  assign byp = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_ptr_t          w_ptr;
    ch_ptr_t          r_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty[c] = (w_ptr == r_ptr);
    assign full[c]  = (w_ptr[PTR_W-1:0] == r_ptr[PTR_W-1:0]) &&
                      (w_ptr[PTR_W] != r_ptr[PTR_W]);

    assign w_fire[c] = q.w_val[c] & q.w_rdy[c] & ~byp[c];
    assign r_fire[c] = deq & gnt_oh[c] & ~byp[c];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (w_fire[c]) w_ptr <= w_ptr + PTR_ONE;
        if (r_fire[c]) r_ptr <= r_ptr + PTR_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (w_fire[c]) mem[w_ptr[PTR_W-1:0]] <= q.w_msg[c*WIDTH +: WIDTH];
    end

    assign head[c] = mem[r_ptr[PTR_W-1:0]];
    assign q.count[c*(PTR_W+1) +: PTR_W+1] = w_ptr - r_ptr;
  end

  always_comb begin
    q.r_msg = head[gnt_bin];
`ifdef QUEUE_BYPASS_EN
    if (empty[gnt_bin]) q.r_msg = q.w_msg[int'(gnt_bin)*WIDTH +: WIDTH];
`endif
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .lock    (stall),
    .en      (deq),
    .gnt_oh  (gnt_oh),
    .gnt_bin (gnt_bin)
  );

endmodule

// File: tb/tb_multi_channel_normal_queue.sv
// Randomised scoreboard bench for multi_channel_normal_queue.
// Reference: per-channel queues plus a round-robin/lock model.
module tb_multi_channel_normal_queue;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int N  = 4;
  localparam int CW = 2;

  typedef struct {
    int          ch;
    logic [31:0] msg;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  multi_channel_normal_queue_if #(.WIDTH(W), .DEPTH(D), .NUM_CH(N)) qif ();

  multi_channel_normal_queue #(
    .WIDTH  (W),
    .DEPTH  (D),
    .NUM_CH (N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (qif)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q [$];
  logic [31:0] mq [N][$];
  logic [31:0] wm [N];
  int          prio = 0;
  bit          locked = 1'b0;
  int          lch = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, act, want, $time);
    end
  endtask

  function automatic int cnt(input int c);
    return int'(qif.count[c*CW +: CW]);
  endfunction

  function automatic int model_grant();
    if (locked) return lch;
    for (int i = 0; i < N; i++)
      if (mq[(prio + i) % N].size() > 0) return (prio + i) % N;
    return 0;
  endfunction

  // One clock of stimulus with model checks and model update
  task automatic step(input logic [N-1:0] wv, input logic rr);
    bit   mv;
    int   g;
    bit   enq [N];
    exp_t e;
    @(negedge clk);
    qif.w_val = wv;
    for (int c = 0; c < N; c++) qif.w_msg[c*W +: W] = wm[c];
    qif.r_rdy = rr;
    #1;
    mv = 1'b0;
    for (int c = 0; c < N; c++) if (mq[c].size() > 0) mv = 1'b1;
    g = model_grant();
    chk("r_val", 32'(qif.r_val), 32'(mv));
    if (mv) chk("r_ch", 32'(qif.r_ch), 32'(g));
    for (int c = 0; c < N; c++) begin
      chk("count", 32'(cnt(c)), 32'(mq[c].size()));
      chk("w_rdy", 32'(qif.w_rdy[c]), 32'(mq[c].size() < D));
      enq[c] = wv[c] && (mq[c].size() < D);
    end
    if (mv && rr) begin
      e.ch  = g;
      e.msg = mq[g][0];
      exp_q.push_back(e);
      void'(mq[g].pop_front());
      prio   = (g + 1) % N;
      locked = 1'b0;
    end else if (mv) begin
      locked = 1'b1;
      lch    = g;
    end
    for (int c = 0; c < N; c++) if (enq[c]) mq[c].push_back(wm[c]);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " r_val"}, 32'(qif.r_val), 32'd0);
    chk({tag, " r_ch"}, 32'(qif.r_ch), 32'd0);
    chk({tag, " w_rdy"}, 32'(qif.w_rdy), 32'd0);
    chk({tag, " count"}, 32'(qif.count), 32'd0);
  endtask

  task automatic model_clear();
    for (int c = 0; c < N; c++) mq[c].delete();
    exp_q.delete();
    prio   = 0;
    locked = 1'b0;
    lch    = 0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    qif.w_val = '0;
    qif.r_rdy = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a dequeue is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && qif.r_val && qif.r_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected dequeue", 32'(qif.r_ch), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("deq r_ch", 32'(qif.r_ch), 32'(e.ch));
          chk("deq r_msg", qif.r_msg, e.msg);
        end
      end
    end
  end

  initial begin
    qif.w_val = '0;
    qif.w_msg = '0;
    qif.r_rdy = 1'b0;
    for (int c = 0; c < N; c++) wm[c] = '0;
    repeat (5) @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // single message on channel 2
    wm[2] = 32'd5;
    step(4'b0100, 1'b0);
    @(posedge clk);
    #1;
    chk("first r_val", 32'(qif.r_val), 32'd1);
    chk("first r_msg", qif.r_msg, 32'd5);
    chk("first r_ch", 32'(qif.r_ch), 32'd2);
    chk("first count2", 32'(cnt(2)), 32'd1);
    step(4'b0000, 1'b1);

    // fill, overflow attempt, drain; repeated for pointer wrap
    for (int r = 0; r < 3; r++) begin
      wm[0] = 32'd5;  step(4'b0001, 1'b0);
      wm[0] = 32'd15; step(4'b0001, 1'b0);
      wm[0] = 32'd10; step(4'b0001, 1'b0);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b0);
    end

    // move the priority pointer to 0, then round-robin drain
    wm[3] = 32'd7;
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b1);
    for (int c = 0; c < N; c++) wm[c] = 32'(100 + c);
    step(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // grant lock: priority at 3, channel 3 stalled, channel 0 arrives
    wm[2] = 32'd22;
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    wm[3] = 32'd33;
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    wm[0] = 32'd44;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // full channel 1 with a simultaneous read
    wm[1] = 32'd61; step(4'b0010, 1'b0);
    wm[1] = 32'd62; step(4'b0010, 1'b0);
    wm[1] = 32'd63; step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) wm[c] = $urandom;
      step(4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // partial fill, then asynchronous reset between edges
    while (exp_q.size() > 0) step(4'b0000, 1'b0);
    for (int c = 0; c < N; c++) wm[c] = 32'(200 + c);
    step(4'b0111, 1'b0);
    mid_reset();
    wm[1] = 32'd77;
    step(4'b0010, 1'b0);
    wm[0] = 32'd78;
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_normal_queue.md
# multi_channel_normal_queue

Single-clock, parametrised successor to the bisynchronous normal queue: NUM_CH independent FIFO channels of DEPTH entries by WIDTH bits, with per-channel val/rdy enqueue ports and one shared val/rdy dequeue port. A round-robin arbiter with grant locking selects the channel presented on the output and tags each message with its channel id. It sits between multiple producers and a single consumer in the same clock domain, such as request merging in front of a shared memory port.

## Interface
- WIDTH, 32: message width in bits.
- DEPTH, 2: entries per channel; power of two, at least 2.
- NUM_CH, 4: number of channels; at least 1.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- w_val  input  NUM_CH  per-channel enqueue valid.
- w_rdy  output  NUM_CH  per-channel enqueue ready.
- w_msg  input  NUM_CH*WIDTH  enqueue data; channel c occupies bits [c*WIDTH +: WIDTH].
- r_val  output  1  dequeue valid.
- r_rdy  input  1  dequeue ready.
- r_msg  output  WIDTH  dequeue data.
- r_ch  output  CH_W  channel id of r_msg; CH_W = max(1, $clog2(NUM_CH)).
- count  output  NUM_CH*(PTR_W+1)  per-channel occupancy; PTR_W = $clog2(DEPTH).

## Operation
- Each channel has a write pointer and a read pointer, each PTR_W+1 bits including a wrap bit. The low PTR_W bits index storage.
- A channel is empty when its two pointers are equal. It is full when the low bits match and the wrap bits differ.
- count[c] = w_ptr - r_ptr, computed modulo 2^(PTR_W+1). Its range is 0..DEPTH.
- w_rdy[c] = !full[c], using registered state only. A full channel with a simultaneous dequeue still deasserts w_rdy. There is no combinational path from r_rdy to w_rdy.
- Enqueue fires on w_val[c] && w_rdy[c]. The message is written to mem[c][w_ptr low bits], and w_ptr increments.
- r_val = OR over all channels of !empty[c].
- r_msg and r_ch come combinationally from the granted channel's head entry.
- Dequeue fires on r_val && r_rdy. The granted channel's r_ptr increments.
- Round-robin arbitration:
  - The priority pointer starts at channel 0.
  - After each dequeue, the priority pointer moves to granted+1, modulo NUM_CH.
  - The grant is the first non-empty channel at or after the priority pointer.
- Grant lock:
  - When r_val && !r_rdy, the lock flag sets and the grant register holds the current channel.
  - While the lock is set, r_ch and r_msg must not change until the dequeue fires.
  - The lock clears on that dequeue.
- Simultaneous enqueue and dequeue on the same channel both take effect. count is then unchanged.
- Storage is not reset. Pointers, priority pointer, lock flag and grant register are reset.
- Reset values:
  - While reset_n is low: w_rdy = 0, r_val = 0, r_ch = 0, count = 0. r_msg is don't-care.
  - First cycle after reset release: w_rdy is all ones.
- Asserting reset mid-operation discards all queued messages immediately and asynchronously.

## Timing
- Enqueue-to-dequeue latency is 1 cycle. A message accepted at edge N is visible on r_val/r_msg after edge N, before edge N+1.
- Throughput:
  - One enqueue per channel per cycle.
  - One dequeue per cycle in total.
  - A channel with depth 2 or more sustains full rate when read back-to-back.
- Fairness: with all channels continuously non-empty and r_rdy high, grants rotate 0,1,…,NUM_CH-1,0,…

## Configuration
- QUEUE_BYPASS_EN defined:
  - An empty channel with w_val high is eligible for arbitration in the same cycle.
  - If it is granted and r_rdy is high, the message passes straight from w_msg to r_msg. Latency is 0, and neither pointer moves.
  - If it is granted and r_rdy is low, the message is stored normally and the lock holds that channel. The stored entry is now that channel's head, so r_msg is stable.
- QUEUE_BYPASS_EN undefined: latency is strictly 1 cycle, and there are no combinational paths from w_* to r_*.

## Structure
- Package normal_queue_pkg holds:
  - Helper constants: PTR_W and CH_W derivation functions.
  - A typedef for the pointer-with-wrapbit type.
- Sub-module rr_arbiter, parametrised by NUM_CH:
  - Inputs: req vector, lock, enable.
  - Outputs: one-hot and binary grant.
  - Owns the priority pointer and the held grant.
- Channel storage and pointers are a generate loop in the top module. They are not a separate sub-module.

## Test plan
- Reset and single message:
  - Stimulus: reset_n low 5 cycles, then high; check reset outputs (w_rdy=0, r_val=0, r_ch=0, count=0).
  - Then enqueue 32'd5 on channel 2.
  - Required response: the next cycle r_val=1, r_msg=5, r_ch=2, count[2]=1.
  - With QUEUE_BYPASS_EN the message appears in the same cycle.
- Fill and wrap:
  - Stimulus: with r_rdy=0, enqueue 5 then 15 on channel 0 (DEPTH=2).
  - Required response: w_rdy[0]=0 and count[0]=2. A third write of 10 is ignored.
  - Then drain: reads return 5 then 15, and r_val=0 afterwards.
  - Repeat 3 times to exercise pointer wrap.
- Round-robin:
  - Stimulus: preload all 4 channels with values 100+c, then hold r_rdy=1.
  - Required response: r_ch sequence 0,1,2,3 with r_msg 100,101,102,103.
- Grant lock:
  - Stimulus: channel 3 non-empty, priority pointer at 3, r_rdy=0. Then write to channel 0.
  - Required response: r_ch stays 3 until r_rdy=1, then the next grant is 0.
- Full with simultaneous read:
  - Stimulus: channel 1 full, r_rdy=1 and w_val[1]=1 in the same cycle.
  - Required response: the write is not accepted that cycle. It is accepted the following cycle; count[1] goes from 2 to 1 to 2.
- Mid-operation reset:
  - Stimulus: pull reset_n low with 3 channels partly full, between clock edges.
  - Required response: r_val=0 and count=0 immediately. After release, the first message read is the first one written after reset.
